// File: rtl/icb_dma_rd.sv
// Read-DMA engine: fetches a block of 32-bit words over an ICB master port,
// buffers them in a FIFO and streams them out on a valid/ready interface.
module icb_dma_rd #(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_OUT    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] stat_wr,
    input  logic [31:0] cfg,
    input  logic [31:0] base_addr,
    output logic [15:0] stat_rd,
    output logic        m_icb_cmd_valid,
    input  logic        m_icb_cmd_ready,
    output logic        m_icb_cmd_read,
    output logic [31:0] m_icb_cmd_addr,
    output logic [31:0] m_icb_cmd_wdata,
    output logic [3:0]  m_icb_cmd_wmask,
    input  logic        m_icb_rsp_valid,
    output logic        m_icb_rsp_ready,
    input  logic [31:0] m_icb_rsp_rdata,
    input  logic        m_icb_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int SW = ((PW > OW) ? PW : OW) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ABORT} state_t;
    state_t state, state_n;

    logic [15:0]   len, len_n;
    logic [31:0]   base;
    logic [16:0]   iss, iss_n;
    logic [OW-1:0] outst, outst_n;
    logic [PW-1:0] wptr, rptr, wptr_n, rptr_n, count_n;
    logic [31:0]   mem [FIFO_DEPTH];
    logic          cmd_valid, cmd_valid_n, cmd_hold;
    logic          done, err, aborted;
    logic          set_done, set_err, set_abt;
    logic          start, go, zstart, clr, abort_go;
    logic          cmd_hs, rsp_dec, push, pop;
    logic          unused_ok;

    assign unused_ok = ^{cfg[31:16], stat_wr[15:3], base_addr[1:0]};

    assign start    = stat_wr[0] && (state == IDLE);
    assign go       = start && (cfg[15:0] != 16'd0);
    assign zstart   = start && (cfg[15:0] == 16'd0);
    assign clr      = stat_wr[1];
    assign abort_go = stat_wr[2] && ((state == RUN) || (state == DRAIN));
    assign cmd_hs   = cmd_valid && m_icb_cmd_ready;
    assign cmd_hold = cmd_valid && !m_icb_cmd_ready;
    assign rsp_dec  = m_icb_rsp_valid && (outst != '0);
    // Responses landing while aborting (or after a reset) are accepted and dropped.
    assign push     = m_icb_rsp_valid && ((state == RUN) || (state == DRAIN)) && !abort_go;
    assign pop      = out_valid && out_ready;
    assign set_err  = push && m_icb_rsp_err;

    always_comb begin
        len_n   = go ? cfg[15:0] : len;
        iss_n   = go ? 17'd0 : iss + {16'd0, cmd_hs};
        outst_n = outst;
        if (cmd_hs && !rsp_dec)
            outst_n = outst + OW'(1);
        else if (!cmd_hs && rsp_dec)
            outst_n = outst - OW'(1);
        wptr_n  = wptr + {{(PW-1){1'b0}}, push};
        rptr_n  = abort_go ? wptr : rptr + {{(PW-1){1'b0}}, pop};
        count_n = wptr_n - rptr_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Exit decisions use post-edge counts so done/busy move in the cycle after the last pop.
    always_comb begin
        state_n  = state;
        set_done = 1'b0;
        set_abt  = 1'b0;
        case (state)
            IDLE: begin
                if (go)          state_n  = RUN;
                else if (zstart) set_done = 1'b1;
            end
            RUN, DRAIN: begin
                if (abort_go) begin
                    state_n = ABORT;
                end else if (iss_n == {1'b0, len}) begin
                    if (outst_n == '0 && count_n == '0) begin
                        state_n  = IDLE;
                        set_done = 1'b1;
                    end else begin
                        state_n  = DRAIN;
                    end
                end
            end
            default: begin
                if (outst_n == '0 && !cmd_hold) begin
                    state_n = IDLE;
                    set_abt = 1'b1;
                end
            end
        endcase
    end

    // FIFO space for every outstanding read is reserved before the command goes out.
    always_comb begin
        cmd_valid_n = cmd_hold;
        if (!cmd_hold && state_n == RUN)
            cmd_valid_n = (iss_n < {1'b0, len_n}) && (outst_n < OW'(MAX_OUT)) &&
                          ((SW'(count_n) + SW'(outst_n)) < SW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            base      <= '0;
            iss       <= '0;
            outst     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            cmd_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            if (go) begin
                len  <= cfg[15:0];
                base <= {base_addr[31:2], 2'b00};
            end
            iss       <= iss_n;
            outst     <= outst_n;
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            cmd_valid <= cmd_valid_n;
            if (start || clr) begin
                done    <= 1'b0;
                err     <= 1'b0;
                aborted <= 1'b0;
            end
            if (set_done) done    <= 1'b1;
            if (set_err)  err     <= 1'b1;
            if (set_abt)  aborted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= m_icb_rsp_rdata;
    end

    always_comb begin
        out_valid       = (wptr != rptr) && (state != ABORT);
        out_data        = out_valid ? mem[rptr[AW-1:0]] : 32'd0;
        stat_rd         = {12'd0, aborted, err, done, (state != IDLE)};
        m_icb_cmd_valid = cmd_valid;
        m_icb_cmd_addr  = base + {13'd0, iss, 2'b00};
        m_icb_cmd_read  = 1'b1;
        m_icb_cmd_wdata = 32'd0;
        m_icb_cmd_wmask = 4'hF;
        m_icb_rsp_ready = 1'b1;
    end

endmodule
